// File: rtl/uniop_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uniop_pkg
//  Purpose  : Opcodes, FSM state encoding, ALU codes and the control-strobe
//             bundle shared by the unioperand control unit.
//  Revision : 1.0
// ============================================================================
package uniop_pkg;

  localparam logic [2:0] c_OPC_LDA = 3'b000;
  localparam logic [2:0] c_OPC_STA = 3'b001;
  localparam logic [2:0] c_OPC_ADD = 3'b010;
  localparam logic [2:0] c_OPC_SUB = 3'b011;
  localparam logic [2:0] c_OPC_JMP = 3'b100;
  localparam logic [2:0] c_OPC_JZ  = 3'b101;
  localparam logic [2:0] c_OPC_JN  = 3'b110;
  localparam logic [2:0] c_OPC_HLT = 3'b111;

  localparam logic [1:0] c_ALU_PASS = 2'b00;
  localparam logic [1:0] c_ALU_ADD  = 2'b01;
  localparam logic [1:0] c_ALU_SUB  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_HALT   = 3'b100
  } state_t;

  typedef struct packed {
    logic       pc_load;
    logic       pc_inc;
    logic       addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_load;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/uniop_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uniop_decoder
//  Purpose  : Combinational Moore/flag decode from state, opcode, flags and
//             memory handshake to the datapath strobe bundle.
//  Revision : 1.0
// ============================================================================
module uniop_decoder
  import uniop_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_acc_zero,
  input  logic       i_acc_neg,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_rd  = 1'b1;
        o_ctrl.ir_load = i_mem_ready;
        o_ctrl.pc_inc  = i_mem_ready;
      end
      S_EXEC: begin
        case (i_opcode)
          c_OPC_LDA: begin
            o_ctrl.addr_sel = 1'b1;
            o_ctrl.mem_rd   = 1'b1;
            o_ctrl.acc_load = i_mem_ready;
            o_ctrl.alu_op   = c_ALU_PASS;
          end
          c_OPC_ADD: begin
            o_ctrl.addr_sel = 1'b1;
            o_ctrl.mem_rd   = 1'b1;
            o_ctrl.acc_load = i_mem_ready;
            o_ctrl.alu_op   = c_ALU_ADD;
          end
          c_OPC_SUB: begin
            o_ctrl.addr_sel = 1'b1;
            o_ctrl.mem_rd   = 1'b1;
            o_ctrl.acc_load = i_mem_ready;
            o_ctrl.alu_op   = c_ALU_SUB;
          end
          c_OPC_STA: begin
            o_ctrl.addr_sel = 1'b1;
            o_ctrl.mem_wr   = 1'b1;
          end
          c_OPC_JMP: o_ctrl.pc_load = 1'b1;
          c_OPC_JZ:  o_ctrl.pc_load = i_acc_zero;
          c_OPC_JN:  o_ctrl.pc_load = i_acc_neg;
          default:   o_ctrl.pc_load = 1'b0;
        endcase
      end
      S_HALT:  o_ctrl.halted = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uniop_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : uniop_control_unit
//  Purpose  : Instruction register, state register and next-state logic of
//             the accumulator processor sequencer; drives counter5b and strobes.
//  Revision : 1.0
// ============================================================================
module uniop_control_unit
  import uniop_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [OPC_W+ADDR_W-1:0] instr_in,
  input  logic                    mem_ready,
  input  logic                    acc_zero,
  input  logic                    acc_neg,
  output logic [ADDR_W-1:0]       pc_in,
  output logic                    pc_load,
  output logic                    pc_inc,
  output logic                    addr_sel,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    ir_load,
  output logic                    acc_load,
  output logic [1:0]              alu_op,
  output logic                    halted
);

  localparam int IW = OPC_W + ADDR_W;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_ir;
  logic [2:0]    w_opc;
  ctrl_t         w_ctrl;

  assign w_opc = r_ir[IW-1 -: 3];

  uniop_decoder u_decoder (
    .i_state     (r_state),
    .i_opcode    (w_opc),
    .i_mem_ready (mem_ready),
    .i_acc_zero  (acc_zero),
    .i_acc_neg   (acc_neg),
    .o_ctrl      (w_ctrl)
  );

  // Jumps (opcode MSB set) finish EXEC in one cycle regardless of memory.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (run) w_state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = (w_opc == c_OPC_HLT) ? S_HALT : S_EXEC;
      S_EXEC:   if (w_opc[2] || mem_ready) w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ctrl.ir_load) r_ir <= instr_in;
    end
  end

  assign pc_in    = r_ir[ADDR_W-1:0];
  assign pc_load  = w_ctrl.pc_load;
  assign pc_inc   = w_ctrl.pc_inc;
  assign addr_sel = w_ctrl.addr_sel;
  assign mem_rd   = w_ctrl.mem_rd;
  assign mem_wr   = w_ctrl.mem_wr;
  assign ir_load  = w_ctrl.ir_load;
  assign acc_load = w_ctrl.acc_load;
  assign alu_op   = w_ctrl.alu_op;
  assign halted   = w_ctrl.halted;

endmodule
`default_nettype wire

// File: tb/tb_uniop_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uniop_control_unit
//  Purpose  : Self-checking bench for uniop_control_unit: directed vector
//             table, multi-cycle corner sequences and a randomized model run.
//  Revision : 1.0
// ============================================================================
module tb_uniop_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       mem_ready = 1'b0;
  logic       acc_zero = 1'b0;
  logic       acc_neg = 1'b0;
  logic [7:0] instr_in = 8'h00;
  logic [4:0] pc_in;
  logic       pc_load, pc_inc, addr_sel, mem_rd, mem_wr, ir_load, acc_load, halted;
  logic [1:0] alu_op;
  logic [14:0] act;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uniop_control_unit #(.ADDR_W(5), .OPC_W(3)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_in(instr_in), .mem_ready(mem_ready),
    .acc_zero(acc_zero), .acc_neg(acc_neg), .pc_in(pc_in), .pc_load(pc_load),
    .pc_inc(pc_inc), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_load(ir_load), .acc_load(acc_load), .alu_op(alu_op), .halted(halted)
  );

  assign act = {pc_in, pc_load, pc_inc, addr_sel, mem_rd, mem_wr, ir_load, acc_load, alu_op, halted};

  function automatic logic [14:0] mk(int pc, int ld, int inc, int asel, int rd, int wr,
                                     int irl, int accl, int alu, int h);
    return {5'(pc), 1'(ld), 1'(inc), 1'(asel), 1'(rd), 1'(wr), 1'(irl), 1'(accl), 2'(alu), 1'(h)};
  endfunction

  task automatic check(input string name, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pc_in,ld,inc,asel,rd,wr,irl,accl,alu,halt)",
               name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: phase of the instruction cycle plus the held instruction.
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_HALT = 4;
  int         m_phase = P_IDLE;
  logic [7:0] m_ir = 8'h00;

  function automatic logic [14:0] model_out();
    int op = int'(m_ir[7:5]);
    int ld = 0, inc = 0, asel = 0, rd = 0, wr = 0, irl = 0, accl = 0, alu = 0, h = 0;
    if (m_phase == P_FETCH) begin
      rd = 1; inc = int'(mem_ready); irl = int'(mem_ready);
    end else if (m_phase == P_EXEC) begin
      if (op < 4) begin
        asel = 1;
        wr   = (op == 1) ? 1 : 0;
        rd   = 1 - wr;
        accl = (mem_ready && op != 1) ? 1 : 0;
        alu  = (op == 2) ? 1 : (op == 3) ? 2 : 0;
      end else begin
        ld = (op == 4 || (op == 5 && acc_zero) || (op == 6 && acc_neg)) ? 1 : 0;
      end
    end else if (m_phase == P_HALT) begin
      h = 1;
    end
    return mk(int'(m_ir[4:0]), ld, inc, asel, rd, wr, irl, accl, alu, h);
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_phase = P_IDLE; m_ir = 8'h00;
    end else begin
      case (m_phase)
        P_IDLE:   if (run) m_phase = P_FETCH;
        P_FETCH:  if (mem_ready) begin m_ir = instr_in; m_phase = P_DECODE; end
        P_DECODE: m_phase = (m_ir[7:5] == 3'd7) ? P_HALT : P_EXEC;
        P_EXEC:   if (m_ir[7:5] >= 3'd4 || mem_ready) m_phase = P_FETCH;
        default:  m_phase = m_phase;
      endcase
    end
  endtask

  typedef struct {
    logic        run, mr, az, an;
    logic [7:0]  instr;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int r, input int m, input int z, input int n, input int ins,
                     input logic [14:0] e);
    tbl.push_back('{1'(r), 1'(m), 1'(z), 1'(n), 8'(ins), e});
  endtask

  logic [14:0] stall_exp[8];

  initial begin
    int inc_cnt, acc_cnt;

    // ---------------- reset hold and release ----------------
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
      acc_zero = 1'($urandom_range(0, 1)); acc_neg = 1'($urandom_range(0, 1));
      instr_in = 8'($urandom);
      #1 check("reset_hold", 15'd0);
    end
    @(negedge clk);
    rst = 1'b1; run = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("idle_after_release", 15'd0);
      @(negedge clk);
    end

    // ---------------- directed vector table ----------------
    add(0,1,0,0,8'h0A, mk( 0,0,0,0,0,0,0,0,0,0));
    add(1,1,0,0,8'h0A, mk( 0,0,0,0,0,0,0,0,0,0));
    add(1,1,0,0,8'h0A, mk( 0,0,1,0,1,0,1,0,0,0));
    add(1,1,0,0,8'h0A, mk(10,0,0,0,0,0,0,0,0,0));
    add(1,1,0,0,8'h0A, mk(10,0,0,1,1,0,0,1,0,0));
    add(1,1,1,0,8'hA7, mk(10,0,1,0,1,0,1,0,0,0));
    add(1,1,1,0,8'hA7, mk( 7,0,0,0,0,0,0,0,0,0));
    add(1,1,1,0,8'hA7, mk( 7,1,0,0,0,0,0,0,0,0));
    add(1,0,0,0,8'hA7, mk( 7,0,0,0,1,0,0,0,0,0));
    add(1,1,0,0,8'hA7, mk( 7,0,1,0,1,0,1,0,0,0));
    add(1,1,0,1,8'hA7, mk( 7,0,0,0,0,0,0,0,0,0));
    add(1,1,0,1,8'hA7, mk( 7,0,0,0,0,0,0,0,0,0));
    add(1,1,0,1,8'hC3, mk( 7,0,1,0,1,0,1,0,0,0));
    add(1,1,0,1,8'hC3, mk( 3,0,0,0,0,0,0,0,0,0));
    add(1,0,0,1,8'hC3, mk( 3,1,0,0,0,0,0,0,0,0));
    add(1,1,0,0,8'h45, mk( 3,0,1,0,1,0,1,0,0,0));
    add(1,1,0,0,8'h45, mk( 5,0,0,0,0,0,0,0,0,0));
    add(1,0,0,0,8'h45, mk( 5,0,0,1,1,0,0,0,1,0));
    add(1,1,0,0,8'h45, mk( 5,0,0,1,1,0,0,1,1,0));
    add(1,1,0,0,8'h61, mk( 5,0,1,0,1,0,1,0,0,0));
    add(1,1,0,0,8'h61, mk( 1,0,0,0,0,0,0,0,0,0));
    add(1,1,0,0,8'h61, mk( 1,0,0,1,1,0,0,1,2,0));
    add(1,1,0,0,8'h3F, mk( 1,0,1,0,1,0,1,0,0,0));
    add(1,1,0,0,8'h3F, mk(31,0,0,0,0,0,0,0,0,0));
    add(1,1,0,0,8'h3F, mk(31,0,0,1,0,1,0,0,0,0));
    add(1,1,1,0,8'hC3, mk(31,0,1,0,1,0,1,0,0,0));
    add(1,1,1,0,8'hC3, mk( 3,0,0,0,0,0,0,0,0,0));
    add(1,1,1,0,8'hC3, mk( 3,0,0,0,0,0,0,0,0,0));
    add(1,1,0,0,8'hE0, mk( 3,0,1,0,1,0,1,0,0,0));
    add(1,1,0,0,8'hE0, mk( 0,0,0,0,0,0,0,0,0,0));
    add(0,1,0,0,8'hE0, mk( 0,0,0,0,0,0,0,0,0,1));
    add(1,1,0,0,8'hE0, mk( 0,0,0,0,0,0,0,0,0,1));
    foreach (tbl[i]) begin
      run = tbl[i].run; mem_ready = tbl[i].mr; acc_zero = tbl[i].az;
      acc_neg = tbl[i].an; instr_in = tbl[i].instr;
      #1 check($sformatf("vec%0d", i), tbl[i].exp);
      @(negedge clk);
    end

    // ---------------- HALT ignores run ----------------
    for (int i = 0; i < 10; i++) begin
      run = 1'(i % 2); mem_ready = 1'($urandom_range(0, 1));
      #1 check("halt_hold", mk(0,0,0,0,0,0,0,0,0,1));
      @(negedge clk);
    end

    // ---------------- LDA with two wait cycles in FETCH and EXEC ----------------
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; run = 1'b1; instr_in = 8'h0A; mem_ready = 1'b0;
    @(negedge clk);
    stall_exp[0] = mk( 0,0,0,0,1,0,0,0,0,0);
    stall_exp[1] = mk( 0,0,0,0,1,0,0,0,0,0);
    stall_exp[2] = mk( 0,0,1,0,1,0,1,0,0,0);
    stall_exp[3] = mk(10,0,0,0,0,0,0,0,0,0);
    stall_exp[4] = mk(10,0,0,1,1,0,0,0,0,0);
    stall_exp[5] = mk(10,0,0,1,1,0,0,0,0,0);
    stall_exp[6] = mk(10,0,0,1,1,0,0,1,0,0);
    stall_exp[7] = mk(10,0,0,0,1,0,0,0,0,0);
    inc_cnt = 0; acc_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      mem_ready = (k == 2 || k == 6);
      #1 check($sformatf("stall_k%0d", k), stall_exp[k]);
      if (k < 7) begin
        inc_cnt += int'(pc_inc);
        acc_cnt += int'(acc_load);
      end
      @(negedge clk);
    end
    check_int("stall_pc_inc_pulses", inc_cnt, 1);
    check_int("stall_acc_load_pulses", acc_cnt, 1);

    // ---------------- reset during STA memory stall ----------------
    instr_in = 8'h3F; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1 check("sta_stall", mk(31,0,0,1,0,1,0,0,0,0));
    #2 rst = 1'b0;
    #1 check("async_reset_drop", 15'd0);
    @(negedge clk);
    rst = 1'b1; run = 1'b0; mem_ready = 1'b1;
    #1 check("post_reset_idle", 15'd0);
    @(negedge clk);
    run = 1'b1;
    #1 check("post_reset_idle_run", 15'd0);
    @(negedge clk);
    #1 check("post_reset_fetch", mk(0,0,1,0,1,0,1,0,0,0));

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst       = (i == 0) ? 1'b0 : 1'($urandom_range(0, 49) != 0);
      run       = 1'($urandom_range(0, 3) != 0);
      mem_ready = 1'($urandom_range(0, 1));
      acc_zero  = 1'($urandom_range(0, 1));
      acc_neg   = 1'($urandom_range(0, 1));
      instr_in  = 8'($urandom);
      #1;
      if (!rst) begin m_phase = P_IDLE; m_ir = 8'h00; end
      check("random", model_out());
      checks++;
      if (pc_load && pc_inc) begin
        errors++;
        $display("FAIL pc_exclusive: got load=%0b inc=%0b expected not both", pc_load, pc_inc);
      end
      @(posedge clk);
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uniop_control_unit.md
# uniop_control_unit

Sequencing control unit for the unioperand (accumulator) processor: holds the instruction register and steps a Moore FSM through IDLE/FETCH/DECODE/EXEC/HALT. It sits directly upstream of the 5-bit program counter (`counter5b`) and drives its `in`, `load` and `inc` inputs. It also generates the memory, accumulator and ALU control strobes for the datapath.

## Interface
- `ADDR_W`, 5, width of operand address and PC; must equal `counter5b` width.
- `OPC_W`, 3, opcode width; instruction width `IW = OPC_W + ADDR_W` (8 by default).
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; leaves IDLE when high.
- `instr_in`  in  IW  instruction word from memory, valid while `mem_ready` is high.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `acc_zero`, `acc_neg`  in  1 each  accumulator flags, combinational from the datapath.
- `pc_in`  out  ADDR_W  jump target = IR[ADDR_W-1:0]; goes to counter `in`.
- `pc_load`, `pc_inc`  out  1 each  counter controls; never high in the same cycle.
- `addr_sel`  out  1  0 = memory address from PC, 1 = from IR operand.
- `mem_rd`, `mem_wr`  out  1 each  memory strobes.
- `ir_load`  out  1  IR capture strobe (exported for trace).
- `acc_load`  out  1  accumulator write enable.
- `alu_op`  out  2  00 pass, 01 add, 10 sub, 11 unused.
- `halted`  out  1  high in HALT.

## Operation
- Opcodes: LDA 000, STA 001, ADD 010, SUB 011, JMP 100, JZ 101, JN 110, HLT 111.
- IDLE: all strobes low. Moves to FETCH when `run`=1.
- FETCH: `addr_sel`=0, `mem_rd`=1. When `mem_ready`=1: `ir_load`=1, `pc_inc`=1, IR <= `instr_in`, next state DECODE. Otherwise stays in FETCH with strobes held.
- DECODE: no strobes. Next state is HALT if opcode is HLT, otherwise EXEC.
- EXEC, memory ops:
  - LDA, ADD and SUB drive `addr_sel`=1, `mem_rd`=1, with `alu_op` 00/01/10 respectively.
  - STA drives `addr_sel`=1, `mem_wr`=1.
  - `acc_load` is asserted only in the cycle where `mem_ready`=1, and only for LDA, ADD and SUB.
  - The state stays in EXEC until `mem_ready`=1, then goes to FETCH.
- EXEC, jumps:
  - One cycle; `mem_ready` is ignored.
  - `pc_load`=1 for JMP, for JZ when `acc_zero`=1, and for JN when `acc_neg`=1. Otherwise `pc_load`=0.
  - Next state is FETCH.
- HALT: `halted`=1, all other strobes low. Exits only by reset; `run` is ignored.
- Outputs are decoded combinationally from state, IR, flags and `mem_ready`. `pc_in` is always IR[ADDR_W-1:0].
- Reset (asserted at any time, including mid-FETCH or mid-EXEC):
  - State goes to IDLE and IR clears to 0 immediately.
  - All outputs read 0.
  - A pending `mem_ready` is discarded.

## Timing
- With `mem_ready` tied high:
  - Memory instructions take 3 cycles (FETCH, DECODE, EXEC).
  - Jumps take 3 cycles.
  - HLT takes 2 cycles to reach HALT.
- PC increments at the FETCH-completing edge. The PC is therefore already PC+1 during DECODE.
- A jump load overrides the PC at the end of EXEC.
- Each memory wait cycle adds exactly one cycle; strobes stay stable throughout the stall.
- Flags are sampled combinationally in EXEC. The datapath guarantees they reflect the accumulator value from before that cycle.
- Release of `rst`: first state change is on the first rising edge after `rst` goes high, and only if `run`=1.

## Structure
- Package `uniop_pkg` holds:
  - opcode localparams;
  - state encoding: IDLE 000, FETCH 001, DECODE 010, EXEC 011, HALT 100;
  - `alu_op` codes.
- Sub-module `uniop_decoder`: combinational; maps opcode, flags and state to the strobe vector. The top level holds the state register, IR and next-state logic.

## Test plan
- Reset: hold `rst`=0 with random inputs. All outputs must be 0 and `pc_in`=0. Release with `run`=0: the block must stay in IDLE.
- LDA: `run`=1, `mem_ready`=1, `instr_in`=8'b000_01010.
  - Cycle 1: `mem_rd`=1, `pc_inc`=1.
  - Cycle 2: no strobes.
  - Cycle 3: `addr_sel`=1, `mem_rd`=1, `acc_load`=1, `alu_op`=00.
- Stall: same LDA with `mem_ready` low for 2 cycles in both FETCH and EXEC. Total must be 7 cycles, with `pc_inc` and `acc_load` each pulsing exactly once.
- Conditional jump: JZ 8'b101_00111.
  - With `acc_zero`=1: `pc_load`=1 and `pc_in`=7 in EXEC.
  - With `acc_zero`=0: `pc_load`=0.
  - Repeat for JN using `acc_neg`.
- HLT: 8'b111_00000 must reach HALT with `halted`=1 two cycles after fetch. It must stay in HALT through 10 cycles of `run` toggling.
- Mid-operation reset: assert `rst`=0 during the EXEC stall of STA. `mem_wr` must drop asynchronously. After release, the next fetch must start from IDLE.
